arith_wb_scheduler: RTL and testbench
=====================================

Name: arith_wb_scheduler

Overview:
Issue and writeback scheduler for the shared arithmetic unit. The arithmetic unit's function paths have different fixed latencies and share one registered result port. This block accepts one tagged operation per cycle and drives the opcode to the unit. It reserves the result-port slot each operation will occupy and stalls issue when two results would collide. At completion it emits the result-mux select, the tag and a valid strobe for register writeback.

Parameters:
LAT_INT, 27, cycles from accept to result for ADD/SUB/ADDWC/SUBWB (opcodes 000-011)
LAT_MUL, 13, cycles for MUL (100)
LAT_FADD, 2, cycles for FADD (101)
LAT_FMUL, 6, cycles for FMUL (111)
MAX_LAT, 32, reservation depth; must exceed every LAT_*
TAG_W, 5, destination tag width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  discard all pending reservations
issue_valid  in  1  requester has an operation
issue_opcode  in  3  operation code
issue_tag  in  TAG_W  destination tag
issue_ready  out  1  operation accepted at this edge if issue_valid=1
au_opcode  out  3  opcode to arithmetic unit function paths
wb_valid  out  1  result on unit output this cycle
wb_sel  out  3  result-mux select (opcode of completing op)
wb_tag  out  TAG_W  tag of completing op
wb_err  out  1  completing op had an illegal opcode
inflight  out  6  accepted, not yet completed operations
idle  out  1  inflight==0

Behaviour:
- Reset (async, immediate): all reservation slots invalid. wb_valid=0, wb_sel=0, wb_tag=0, wb_err=0, inflight=0, au_opcode=000. idle=1, issue_ready follows the comb rule.
- Latency L(op): from the parameters. Opcode 110 is illegal: L=1, accepted normally, completes with wb_err=1.
- Reservation state: MAX_LAT slots, each holds {valid, opcode, tag, err}. Every edge, slot i takes slot i+1 and the top slot takes empty.
- Accept in cycle k (issue_valid & issue_ready): slot L-1 is written at the same edge, overriding the shift. The result is therefore in slot 0 during cycle k+L.
- wb_valid/wb_sel/wb_tag/wb_err are driven directly from slot 0 (registered, no comb path from inputs).
- issue_ready is combinational: 0 if flush=1; else 0 if L(issue_opcode) < MAX_LAT and slot L is currently valid; else 1. It may depend on issue_opcode. A requester must hold valid, opcode and tag until accepted.
- au_opcode: registered. Loads issue_opcode on accept; otherwise holds its value.
- No ordering guarantee: a short op issued after a long op may complete first. Tags identify results.
- flush=1 at an edge: all slots are cleared, no accept occurs, inflight←0, and the next cycle shows wb_valid=0. A result in slot 0 during the flush cycle is still presented that cycle.
- inflight: +1 on accept, -1 when wb_valid=1, unchanged if both occur. It saturates at 63 and never underflows.
- Back-to-back same-op issue: always accepted, since slots L and L-1 shift in lockstep.
- Reset mid-operation: every pending result is lost, with no wb_valid afterwards.

Test Plan:
- Reset then single ADD, tag 3, accepted cycle 10 -> wb_valid=1, wb_sel=000, wb_tag=3 only in cycle 37; inflight 1 for cycles 11-37, 0 from cycle 38.
- MUL tag 1 accepted cycle 0, FMUL tag 2 requested cycle 7 (target slot 13 occupied) -> issue_ready=0 in cycle 7. Accepted cycle 8 with completion cycle 14; MUL completes cycle 13.
- FADD issued every cycle for 10 cycles, tags 0-9 -> all accepted, wb_valid continuous in cycles 2-11 with tags in order.
- ADD tag 4 in cycle 0, then FADD tag 5 in cycle 1 -> FADD completes cycle 3, ADD completes cycle 27; wb_tag order 5 then 4.
- Opcode 110 tag 7 accepted cycle 5 -> cycle 6 wb_valid=1, wb_err=1, wb_tag=7.
- MUL accepted cycle 0, flush in cycle 4 -> issue_ready=0 in cycle 4, no wb_valid in cycle 13, inflight=0 from cycle 5. Repeat with rst pulsed mid-cycle 4 -> outputs zero immediately.

Source files
------------

// File: rtl/arith_wb_scheduler.sv
// arith_wb_scheduler
//   Issue and writeback scheduler for the shared arithmetic unit. Every
//   accepted operation reserves the result-port slot it will occupy L cycles
//   later. Issue is refused whenever that slot is already taken. Slot 0 of
//   the reservation line drives the writeback strobe, mux select and tag.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   flush        in   drop every pending reservation, blocks issue
//   issue_valid  in   requester has an operation
//   issue_opcode in   operation code (110 is illegal, completes with error)
//   issue_tag    in   destination tag
//   issue_ready  out  operation accepted at this edge if issue_valid=1
//   au_opcode    out  opcode presented to the arithmetic unit (registered)
//   wb_valid     out  a result is on the unit output this cycle
//   wb_sel       out  result-mux select (opcode of the completing op)
//   wb_tag       out  tag of the completing op
//   wb_err       out  completing op had an illegal opcode
//   inflight     out  accepted, not yet completed operations
//   idle         out  inflight == 0
module arith_wb_scheduler #(
   parameter int LAT_INT  = 27,
   parameter int LAT_MUL  = 13,
   parameter int LAT_FADD = 2,
   parameter int LAT_FMUL = 6,
   parameter int MAX_LAT  = 32,
   parameter int TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             issue_valid,
   input  logic [2:0]       issue_opcode,
   input  logic [TAG_W-1:0] issue_tag,
   output logic             issue_ready,
   output logic [2:0]       au_opcode,
   output logic             wb_valid,
   output logic [2:0]       wb_sel,
   output logic [TAG_W-1:0] wb_tag,
   output logic             wb_err,
   output logic [5:0]       inflight,
   output logic             idle
);

   localparam int LW = $clog2(MAX_LAT + 1);

   // Reservation line: slot i holds the op that completes i cycles from now.
   logic             slot_valid [MAX_LAT];
   logic [2:0]       slot_op    [MAX_LAT];
   logic [TAG_W-1:0] slot_tag   [MAX_LAT];
   logic             slot_err   [MAX_LAT];

   // Contents each slot inherits when nothing is written into it.
   logic             sh_valid [MAX_LAT];
   logic [2:0]       sh_op    [MAX_LAT];
   logic [TAG_W-1:0] sh_tag   [MAX_LAT];
   logic             sh_err   [MAX_LAT];

   logic [LW-1:0] lat;
   logic          target_busy;
   logic          illegal;
   logic          accept;

   always_comb begin
      lat = LW'(1);
      case (issue_opcode)
         3'b000, 3'b001, 3'b010, 3'b011: lat = LW'(LAT_INT);
         3'b100:                         lat = LW'(LAT_MUL);
         3'b101:                         lat = LW'(LAT_FADD);
         3'b111:                         lat = LW'(LAT_FMUL);
         default:                        lat = LW'(1);
      endcase
   end

   // The new op would land in slot L-1 after this edge; that collides with
   // whatever currently sits in slot L (it shifts down into the same place).
   always_comb begin
      target_busy = 1'b0;
      for (int i = 0; i < MAX_LAT; i++) begin
         if (lat == LW'(i) && slot_valid[i]) begin
            target_busy = 1'b1;
         end
      end
   end

   assign illegal     = (issue_opcode == 3'b110);
   assign issue_ready = !flush && !target_busy;
   assign accept      = issue_valid && issue_ready;

   genvar gi;
   generate
      for (gi = 0; gi < MAX_LAT; gi++) begin : g_slot
         if (gi == MAX_LAT - 1) begin : g_top
            assign sh_valid[gi] = 1'b0;
            assign sh_op[gi]    = 3'b000;
            assign sh_tag[gi]   = '0;
            assign sh_err[gi]   = 1'b0;
         end else begin : g_mid
            assign sh_valid[gi] = slot_valid[gi+1];
            assign sh_op[gi]    = slot_op[gi+1];
            assign sh_tag[gi]   = slot_tag[gi+1];
            assign sh_err[gi]   = slot_err[gi+1];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               slot_valid[gi] <= 1'b0;
               slot_op[gi]    <= 3'b000;
               slot_tag[gi]   <= '0;
               slot_err[gi]   <= 1'b0;
            end else if (flush) begin
               slot_valid[gi] <= 1'b0;
               slot_op[gi]    <= 3'b000;
               slot_tag[gi]   <= '0;
               slot_err[gi]   <= 1'b0;
            end else if (accept && lat == LW'(gi + 1)) begin
               slot_valid[gi] <= 1'b1;
               slot_op[gi]    <= issue_opcode;
               slot_tag[gi]   <= issue_tag;
               slot_err[gi]   <= illegal;
            end else begin
               slot_valid[gi] <= sh_valid[gi];
               slot_op[gi]    <= sh_op[gi];
               slot_tag[gi]   <= sh_tag[gi];
               slot_err[gi]   <= sh_err[gi];
            end
         end
      end
   endgenerate

   assign wb_valid = slot_valid[0];
   assign wb_sel   = slot_op[0];
   assign wb_tag   = slot_tag[0];
   assign wb_err   = slot_err[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         au_opcode <= 3'b000;
      end else if (accept) begin
         au_opcode <= issue_opcode;
      end
   end

   // Saturating up/down count; simultaneous accept and completion cancel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= 6'd0;
      end else if (flush) begin
         inflight <= 6'd0;
      end else begin
         case ({accept, slot_valid[0]})
            2'b10:   if (inflight != 6'd63) inflight <= inflight + 6'd1;
            2'b01:   if (inflight != 6'd0)  inflight <= inflight - 6'd1;
            default: inflight <= inflight;
         endcase
      end
   end

   assign idle = (inflight == 6'd0);

endmodule

// File: tb/tb_arith_wb_scheduler.sv
module tb_arith_wb_scheduler;

   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             issue_valid;
   logic [2:0]       issue_opcode;
   logic [TAG_W-1:0] issue_tag;
   logic             issue_ready;
   logic [2:0]       au_opcode;
   logic             wb_valid;
   logic [2:0]       wb_sel;
   logic [TAG_W-1:0] wb_tag;
   logic             wb_err;
   logic [5:0]       inflight;
   logic             idle;

   arith_wb_scheduler dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_tag(issue_tag),
      .issue_ready(issue_ready), .au_opcode(au_opcode),
      .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_tag(wb_tag), .wb_err(wb_err),
      .inflight(inflight), .idle(idle)
   );

   always #5 clk = ~clk;

   // Reference model: completions keyed by the absolute cycle they appear in.
   typedef struct {
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
      logic             err;
   } rec_t;

   rec_t       comp [int];
   int         cyc;
   logic [2:0] au_model;

   int n_pass = 0;
   int n_total = 0;

   // Values sampled during the most recent step.
   logic             last_ready;
   logic             last_wb_valid;
   logic [2:0]       last_wb_sel;
   logic [TAG_W-1:0] last_wb_tag;
   logic             last_wb_err;
   logic             last_acc;
   int               samp_cyc;

   function automatic int lat_of(input logic [2:0] op);
      case (op)
         3'd0, 3'd1, 3'd2, 3'd3: return 27;
         3'd4:                   return 13;
         3'd5:                   return 2;
         3'd7:                   return 6;
         default:                return 1;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
   endtask

   function automatic int pending_count();
      int n = 0;
      foreach (comp[k]) if (k >= cyc) n++;
      return n;
   endfunction

   // One clock cycle: drive inputs, check every output against the model
   // mid-cycle, then advance the model across the edge.
   task automatic step(input logic v, input logic [2:0] op,
                       input logic [TAG_W-1:0] tg, input logic fl);
      logic pred_ready;
      int   n_inf;
      int   dels[$];
      issue_valid  = v;
      issue_opcode = op;
      issue_tag    = tg;
      flush        = fl;
      @(negedge clk);
      pred_ready = !fl && !comp.exists(cyc + lat_of(op));
      chk("issue_ready", int'(issue_ready), int'(pred_ready));
      if (comp.exists(cyc)) begin
         chk("wb_valid", int'(wb_valid), 1);
         chk("wb_sel", int'(wb_sel), int'(comp[cyc].op));
         chk("wb_tag", int'(wb_tag), int'(comp[cyc].tag));
         chk("wb_err", int'(wb_err), int'(comp[cyc].err));
      end else begin
         chk("wb_valid", int'(wb_valid), 0);
      end
      n_inf = pending_count();
      chk("inflight", int'(inflight), n_inf);
      chk("idle", int'(idle), int'(n_inf == 0));
      chk("au_opcode", int'(au_opcode), int'(au_model));
      last_ready    = issue_ready;
      last_wb_valid = wb_valid;
      last_wb_sel   = wb_sel;
      last_wb_tag   = wb_tag;
      last_wb_err   = wb_err;
      samp_cyc      = cyc;
      last_acc      = v && pred_ready;
      @(posedge clk);
      if (fl) begin
         foreach (comp[k]) if (k > cyc) dels.push_back(k);
         foreach (dels[j]) comp.delete(dels[j]);
      end else if (v && pred_ready) begin
         comp[cyc + lat_of(op)] = '{op: op, tag: tg, err: (op == 3'd6)};
         au_model = op;
      end
      if (comp.exists(cyc)) comp.delete(cyc);
      cyc++;
      #1;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, '0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         if (comp.num() == 0) break;
         step(1'b0, 3'd0, '0, 1'b0);
      end
      chk("drain_done", comp.num(), 0);
   endtask

   typedef struct {
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
      int               lat;
      logic             err;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int               c0;
      int               meas;
      logic             hv;
      logic [2:0]       hop;
      logic [TAG_W-1:0] htg;
      logic             hfl;

      vecs[0] = '{op: 3'd0, tag: 5'd3,  lat: 27, err: 1'b0};
      vecs[1] = '{op: 3'd1, tag: 5'd11, lat: 27, err: 1'b0};
      vecs[2] = '{op: 3'd2, tag: 5'd17, lat: 27, err: 1'b0};
      vecs[3] = '{op: 3'd3, tag: 5'd31, lat: 27, err: 1'b0};
      vecs[4] = '{op: 3'd4, tag: 5'd1,  lat: 13, err: 1'b0};
      vecs[5] = '{op: 3'd5, tag: 5'd20, lat: 2,  err: 1'b0};
      vecs[6] = '{op: 3'd6, tag: 5'd7,  lat: 1,  err: 1'b1};
      vecs[7] = '{op: 3'd7, tag: 5'd2,  lat: 6,  err: 1'b0};

      rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_opcode = 3'd0; issue_tag = '0;
      cyc = 0; au_model = 3'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wb_valid", int'(wb_valid), 0);
      chk("rst_wb_sel", int'(wb_sel), 0);
      chk("rst_wb_tag", int'(wb_tag), 0);
      chk("rst_wb_err", int'(wb_err), 0);
      chk("rst_inflight", int'(inflight), 0);
      chk("rst_idle", int'(idle), 1);
      chk("rst_au_opcode", int'(au_opcode), 0);
      chk("rst_ready", int'(issue_ready), 1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Latency / select / error per opcode from an idle unit.
      for (int r = 0; r < 8; r++) begin
         drain();
         c0 = cyc;
         step(1'b1, vecs[r].op, vecs[r].tag, 1'b0);
         chk("vec_accept", int'(last_ready), 1);
         meas = -1;
         for (int n = 0; n < 40; n++) begin
            step(1'b0, 3'd0, '0, 1'b0);
            if (last_wb_valid) begin
               meas = samp_cyc - c0;
               break;
            end
         end
         chk("vec_latency", meas, vecs[r].lat);
         chk("vec_tag", int'(last_wb_tag), int'(vecs[r].tag));
         chk("vec_sel", int'(last_wb_sel), int'(vecs[r].op));
         chk("vec_err", int'(last_wb_err), int'(vecs[r].err));
      end

      // MUL then FMUL whose target slot is taken by the MUL.
      drain();
      c0 = cyc;
      step(1'b1, 3'd4, 5'd1, 1'b0);
      idle_steps(6);
      step(1'b1, 3'd7, 5'd2, 1'b0);
      chk("fmul_blocked", int'(last_ready), 0);
      step(1'b1, 3'd7, 5'd2, 1'b0);
      chk("fmul_accepted", int'(last_ready), 1);
      idle_steps(4);
      step(1'b0, 3'd0, '0, 1'b0);
      chk("mul_done_tag", int'(last_wb_tag), 1);
      chk("mul_done_cycle", samp_cyc - c0, 13);
      step(1'b0, 3'd0, '0, 1'b0);
      chk("fmul_done_tag", int'(last_wb_tag), 2);
      chk("fmul_done_valid", int'(last_wb_valid), 1);

      // Ten back-to-back FADDs.
      drain();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 3'd5, 5'(i), 1'b0);
         chk("fadd_b2b_ready", int'(last_ready), 1);
      end
      drain();

      // ADD then FADD: the FADD overtakes.
      step(1'b1, 3'd0, 5'd4, 1'b0);
      step(1'b1, 3'd5, 5'd5, 1'b0);
      drain();

      // Flush with a MUL pending.
      c0 = cyc;
      step(1'b1, 3'd4, 5'd9, 1'b0);
      idle_steps(3);
      step(1'b1, 3'd0, 5'd9, 1'b1);
      chk("flush_ready", int'(last_ready), 0);
      step(1'b0, 3'd0, '0, 1'b0);
      chk("flush_inflight", int'(inflight), 0);
      idle_steps(10);

      // Reset pulsed mid-cycle with a MUL pending.
      step(1'b1, 3'd4, 5'd12, 1'b0);
      idle_steps(3);
      issue_valid = 1'b0; flush = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("arst_wb_valid", int'(wb_valid), 0);
      chk("arst_inflight", int'(inflight), 0);
      chk("arst_idle", int'(idle), 1);
      chk("arst_au_opcode", int'(au_opcode), 0);
      rst = 1'b0;
      comp.delete();
      au_model = 3'd0;
      idle_steps(15);

      // Randomized traffic against the model; requests held until accepted.
      hv = 1'b0; hop = 3'd0; htg = '0;
      for (int i = 0; i < 800; i++) begin
         if (!(hv && !last_acc)) begin
            hv  = ($urandom_range(99, 0) < 55);
            hop = 3'($urandom_range(7, 0));
            htg = TAG_W'($urandom);
         end
         hfl = ($urandom_range(99, 0) < 3);
         step(hv, hop, htg, hfl);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
